// File: rtl/tpu_pin_bridge.sv
// Host pin protocol engine: req/ack byte handshake on the TT pins driving the tpu core memory port.
// Optional TPU_BRIDGE_AUTOINC_EN adds address auto-increment plus WRITE_NEXT (0x5) / READ_NEXT (0x6).
module tpu_pin_bridge #(
    parameter int ADDR_W     = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ui_in,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uo_out,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic              tpu_start,
    input  logic              tpu_busy,
    input  logic              tpu_done
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_OP,
        S_WADDR,
        S_WDATA,
        S_RADDR,
        S_RD_WAIT,
        S_RD_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_req_s1, r_req_s2, r_req_s3;
    logic               r_ack, w_ack_nxt;
    logic               r_err, w_err_nxt;
    logic [7:0]         r_uo, w_uo_nxt;
    logic               r_we, w_we_nxt;
    logic               r_re, w_re_nxt;
    logic               r_start, w_start_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr_nxt;
    logic [7:0]         r_wdata, w_wdata_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic               w_req_rise;
    logic               w_accept;
    logic [3:0]         w_opcode;
    logic [ADDR_W-1:0]  w_addr_byte;
    logic [ADDR_W-1:0]  w_addr_inc;
    logic               w_unused_uio;

    assign w_req_rise   = r_req_s2 & ~r_req_s3;
    assign w_accept     = w_req_rise & ~r_ack;
    assign w_opcode     = ui_in[7:4];
    assign w_addr_byte  = ADDR_W'(ui_in);
    assign w_unused_uio = ^uio_in[7:1];
`ifdef TPU_BRIDGE_AUTOINC_EN
    assign w_addr_inc   = r_addr + ADDR_W'(1);
`else
    assign w_addr_inc   = r_addr;
`endif

    assign uo_out    = r_uo;
    assign uio_out   = {4'b0000, tpu_busy, r_err, r_ack, 1'b0};
    assign uio_oe    = 8'b0000_1110;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign mem_re    = r_re;
    assign tpu_start = r_start;

    // NOTE: every next-state variable gets its hold/idle default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_ack_nxt      = r_ack & r_req_s2;
        w_err_nxt      = r_err;
        w_uo_nxt       = r_uo;
        w_we_nxt       = 1'b0;
        w_re_nxt       = 1'b0;
        w_start_nxt    = 1'b0;
        w_addr_nxt     = r_addr;
        w_mem_addr_nxt = r_mem_addr;
        w_wdata_nxt    = r_wdata;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            S_OP: begin
                if (w_accept) begin
                    w_ack_nxt = 1'b1;
                    case (w_opcode)
                        4'h0: w_err_nxt = 1'b0;
                        4'h1: w_state_nxt = S_WADDR;
                        4'h2: w_state_nxt = S_RADDR;
                        4'h3: begin
                            if (tpu_busy) w_err_nxt = 1'b1;
                            else          w_start_nxt = 1'b1;
                        end
                        4'h4: w_uo_nxt = {tpu_busy, tpu_done, r_err, 5'b0};
`ifdef TPU_BRIDGE_AUTOINC_EN
                        4'h5: w_state_nxt = S_WDATA;
                        4'h6: begin
                            w_ack_nxt      = 1'b0;
                            w_re_nxt       = 1'b1;
                            w_mem_addr_nxt = r_addr;
                            w_cnt_nxt      = '0;
                            w_state_nxt    = S_RD_WAIT;
                        end
`endif
                        default: w_err_nxt = 1'b1;
                    endcase
                end
            end
            S_WADDR: begin
                if (w_accept) begin
                    w_addr_nxt  = w_addr_byte;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_WDATA;
                end
            end
            S_WDATA: begin
                if (w_accept) begin
                    w_mem_addr_nxt = r_addr;
                    w_wdata_nxt    = ui_in;
                    w_we_nxt       = 1'b1;
                    w_ack_nxt      = 1'b1;
                    w_addr_nxt     = w_addr_inc;
                    w_state_nxt    = S_OP;
                end
            end
            S_RADDR: begin
                // The read address byte is acknowledged only once data (or the timeout) is in.
                if (w_accept) begin
                    w_addr_nxt     = w_addr_byte;
                    w_mem_addr_nxt = w_addr_byte;
                    w_re_nxt       = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    w_uo_nxt    = mem_rdata;
                    w_state_nxt = S_RD_DONE;
                end else if (r_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                    w_uo_nxt    = 8'hEE;
                    w_err_nxt   = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_addr_nxt  = w_addr_inc;
                    w_state_nxt = S_OP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RD_DONE: begin
                w_ack_nxt   = 1'b1;
                w_addr_nxt  = w_addr_inc;
                w_state_nxt = S_OP;
            end
            default: w_state_nxt = S_OP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_OP;
            // Synchronizer resets high: a req held through reset must be seen low before it counts.
            r_req_s1   <= 1'b1;
            r_req_s2   <= 1'b1;
            r_req_s3   <= 1'b1;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_uo       <= 8'h00;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_start    <= 1'b0;
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_wdata    <= 8'h00;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_s1   <= uio_in[0];
            r_req_s2   <= r_req_s1;
            r_req_s3   <= r_req_s2;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_uo       <= w_uo_nxt;
            r_we       <= w_we_nxt;
            r_re       <= w_re_nxt;
            r_start    <= w_start_nxt;
            r_addr     <= w_addr_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tpu_pin_bridge.sv
// Self-checking bench for tpu_pin_bridge: command-level host model, strobe scoreboard and a memory responder.
module tb_tpu_pin_bridge;

    localparam int RD_TO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we, mem_re, mem_rvalid, tpu_start, tpu_busy, tpu_done;

    tpu_pin_bridge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .uo_out     (uo_out),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .tpu_start  (tpu_start),
        .tpu_busy   (tpu_busy),
        .tpu_done   (tpu_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Host-visible model
    logic [7:0]  m_uo, m_addr;
    logic        m_err;
    logic [7:0]  mem_model [256];
    logic [15:0] exp_wq [$];
    logic [7:0]  exp_rq [$];
    int          exp_start = 0, act_start = 0;

    // Responder / monitor control
    bit          mon_en = 1'b0;
    bit          noise_en = 1'b0;
    int          rsp_delay = 0, rsp_cnt = 0;
    logic [7:0]  rd_addr = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: fixed pins every cycle, strobes against scoreboard, return byte/err while ack is high.
    always @(negedge clk) begin
        logic [15:0] w;
        logic [7:0]  a;
        mem_rvalid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_model[rd_addr];
            end
        end else if (noise_en && $urandom_range(0, 3) == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 8'($urandom);
        end
        if (mon_en) begin
            check("uio_oe", uio_oe, 8'h0E);
            check("uio_fixed_bits", {uio_out[7:4], uio_out[0]}, 5'b0);
            check("busy_bit", uio_out[3], tpu_busy);
            if (uio_out[1]) begin
                check("uo_at_ack", uo_out, m_uo);
                check("err_at_ack", uio_out[2], m_err);
            end
            if (mem_we) begin
                check("we_expected", exp_wq.size() > 0, 1);
                if (exp_wq.size() > 0) begin
                    w = exp_wq.pop_front();
                    check("we_addr", mem_addr, w[15:8]);
                    check("we_data", mem_wdata, w[7:0]);
                end
            end
            if (mem_re) begin
                check("re_expected", exp_rq.size() > 0, 1);
                if (exp_rq.size() > 0) begin
                    a = exp_rq.pop_front();
                    check("re_addr", mem_addr, a);
                end
                rsp_cnt = rsp_delay;
                rd_addr = mem_addr;
            end
            if (tpu_start) act_start++;
        end
    end

    // One host byte: req up, bounded wait for ack with latency check, req down, bounded wait for ack low.
    task automatic send(input logic [7:0] b, input int lat);
        int n;
        bit got;
        ui_in = b;
        uio_in[7:1] = 7'($urandom);
        uio_in[0] = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (uio_out[1]) got = 1'b1;
        end
        check("ack_seen", got, 1);
        if (got) check("ack_latency", n, lat);
        uio_in[0] = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            tick();
            n++;
            if (!uio_out[1]) got = 1'b1;
        end
        check("ack_fall_latency", n, 3);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        m_uo = 8'h00;
        m_err = 1'b0;
        m_addr = 8'h00;
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio_out", uio_out, {4'b0, tpu_busy, 3'b000});
        check("rst_strobes", {mem_we, mem_re, tpu_start}, 3'b000);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        mon_en = 1'b1;
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int read_lat(input int delay);
        if (delay > 0 && delay <= RD_TO - 1) return 5 + delay;
        return 3 + RD_TO;
    endfunction

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
        send({4'h1, 4'($urandom)}, 3);
        send(a, 3);
        exp_wq.push_back({a, d});
        mem_model[a] = d;
`ifdef TPU_BRIDGE_AUTOINC_EN
        m_addr = a + 8'd1;
`endif
        send(d, 3);
        check("wq_drained", exp_wq.size(), 0);
    endtask

    task automatic finish_read(input logic [7:0] a, input int delay);
        exp_rq.push_back(a);
        if (delay > 0 && delay <= RD_TO - 1) begin
            m_uo = mem_model[a];
        end else begin
            m_uo = 8'hEE;
            m_err = 1'b1;
        end
`ifdef TPU_BRIDGE_AUTOINC_EN
        m_addr = a + 8'd1;
`endif
    endtask

    // delay = cycles from mem_re to mem_rvalid; 0 means the core never answers.
    task automatic cmd_read(input logic [7:0] a, input int delay);
        noise_en = 1'b0;
        rsp_delay = delay;
        send({4'h2, 4'($urandom)}, 3);
        finish_read(a, delay);
        send(a, read_lat(delay));
        check("rq_drained", exp_rq.size(), 0);
    endtask

    task automatic cmd_start();
        if (tpu_busy) m_err = 1'b1;
        else          exp_start++;
        send({4'h3, 4'($urandom)}, 3);
        check("start_pulses", act_start, exp_start);
    endtask

    task automatic cmd_status();
        m_uo = {tpu_busy, tpu_done, m_err, 5'b0};
        send({4'h4, 4'($urandom)}, 3);
    endtask

    task automatic cmd_clear();
        m_err = 1'b0;
        send({4'h0, 4'($urandom)}, 3);
    endtask

    task automatic cmd_illegal(input logic [3:0] op);
        m_err = 1'b1;
        send({op, 4'($urandom)}, 3);
    endtask

`ifdef TPU_BRIDGE_AUTOINC_EN
    task automatic cmd_wnext(input logic [7:0] d);
        send({4'h5, 4'($urandom)}, 3);
        exp_wq.push_back({m_addr, d});
        mem_model[m_addr] = d;
        m_addr = m_addr + 8'd1;
        send(d, 3);
        check("wq_drained", exp_wq.size(), 0);
    endtask

    task automatic cmd_rnext(input int delay);
        noise_en = 1'b0;
        rsp_delay = delay;
        finish_read(m_addr, delay);
        send({4'h6, 4'($urandom)}, read_lat(delay));
        check("rq_drained", exp_rq.size(), 0);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int sel;
        rst_n = 1'b0;
        ui_in = 8'h10;
        uio_in = 8'h01;
        tpu_busy = 1'b0;
        tpu_done = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);

        // req held high through reset must not produce a byte
        do_reset();
        acc = 1'b0;
        repeat (8) begin
            tick();
            acc |= uio_out[1];
        end
        check("held_req_no_ack", acc, 0);
        uio_in[0] = 1'b0;
        repeat (4) tick();

        // Directed: write, read with data, read timeout
        cmd_write(8'h2A, 8'h5C);
        mem_model[8'h07] = 8'hA5;
        cmd_read(8'h07, 4);
        check("lit_read_data", uo_out, 8'hA5);
        cmd_read(8'h07, 0);
        check("lit_timeout_uo", uo_out, 8'hEE);
        check("lit_timeout_err", uio_out[2], 1);
        cmd_clear();

        // START idle/busy, STATUS, clear
        tpu_busy = 1'b0;
        cmd_start();
        tpu_busy = 1'b1;
        cmd_start();
        tpu_done = 1'b0;
        cmd_status();
        check("lit_status", uo_out, 8'hA0);
        cmd_clear();
        check("lit_err_cleared", uio_out[2], 0);
        tpu_busy = 1'b0;

        // Illegal opcode, FSM must be back in OP
        cmd_illegal(4'h9);
        check("lit_illegal_err", uio_out[2], 1);
        cmd_write(8'h80, 8'h3C);
        cmd_clear();

        // Timeout boundary: last waiting cycle still delivers data, one later times out
        cmd_read(8'h2A, RD_TO - 1);
        cmd_read(8'h2A, RD_TO);
        cmd_clear();

        // Reset between address and data bytes of a WRITE: no write may appear
        send(8'h10, 3);
        send(8'h33, 3);
        do_reset();
        repeat (5) tick();
        cmd_write(8'h34, 8'h77);

        // Reset while a read is pending: response is dropped, uo stays 0
        noise_en = 1'b0;
        rsp_delay = 6;
        send(8'h20, 3);
        exp_rq.push_back(8'h55);
        ui_in = 8'h55;
        uio_in[0] = 1'b1;
        repeat (6) tick();
        do_reset();
        acc = 1'b0;
        repeat (10) begin
            tick();
            acc |= uio_out[1];
        end
        check("rd_dropped_no_ack", acc, 0);
        check("rd_dropped_uo", uo_out, 8'h00);
        uio_in[0] = 1'b0;
        repeat (4) tick();

`ifdef TPU_BRIDGE_AUTOINC_EN
        cmd_write(8'hFF, 8'h42);
        send(8'h5A, 3);
        exp_wq.push_back({8'h00, 8'h11});
        mem_model[8'h00] = 8'h11;
        m_addr = 8'h01;
        send(8'h11, 3);
        check("lit_wrap_write", exp_wq.size(), 0);
`else
        cmd_illegal(4'h5);
        check("lit_op5_illegal", uio_out[2], 1);
        cmd_clear();
`endif

        // Randomized command mix with rvalid noise while idle
        noise_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1: cmd_write(8'($urandom), 8'($urandom));
                2, 3: cmd_read(8'($urandom), $urandom_range(0, RD_TO + 2));
                4: cmd_start();
                5: cmd_status();
                6: cmd_clear();
`ifdef TPU_BRIDGE_AUTOINC_EN
                7: cmd_illegal(4'($urandom_range(7, 15)));
                8: begin
                    if ($urandom_range(0, 1) == 1) cmd_wnext(8'($urandom));
                    else cmd_rnext($urandom_range(0, RD_TO + 2));
                end
`else
                7, 8: cmd_illegal(4'($urandom_range(5, 15)));
`endif
                default: begin
                    tpu_busy = 1'($urandom);
                    tpu_done = 1'($urandom);
                    tick();
                end
            endcase
            noise_en = 1'b1;
        end

        repeat (25) tick();
        check("final_wq_empty", exp_wq.size(), 0);
        check("final_rq_empty", exp_rq.size(), 0);
        check("final_start_pulses", act_start, exp_start);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
